// File: rtl/seq_shifter.sv
// seq_shifter: multi-cycle shifter/rotator that performs one bit-step per clock,
// with valid/ready handshakes on both the request and the result side.
module seq_shifter #(
  parameter int WIDTH = 16,
  parameter int AMT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amount,
  input  logic [2:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic             out_zero,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [2:0] MODE_NONE = 3'b000;
  localparam logic [2:0] MODE_LSR  = 3'b001;
  localparam logic [2:0] MODE_LSL  = 3'b010;
  localparam logic [2:0] MODE_ASR  = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_ROL  = 3'b101;

  localparam logic [AMT_W-1:0] WIDTH_AMT = AMT_W'(WIDTH);
  localparam logic [AMT_W-1:0] AMT_ZERO  = {AMT_W{1'b0}};
  localparam logic [AMT_W-1:0] AMT_ONE   = {{(AMT_W-1){1'b0}}, 1'b1};

  state_t           state_r;
  logic [WIDTH-1:0] data_r;
  logic [AMT_W-1:0] cnt_r;
  logic [2:0]       mode_r;
  logic             carry_r;
  logic             zero_r;
  logic             sign_r;
  logic             over_r;
  logic             valid_r;
  logic             ready_r;
  logic             busy_r;

  logic [AMT_W-1:0] n_s;
  logic [2:0]       mode_s;
  logic             over_s;
  logic [WIDTH-1:0] step_data_s;
  logic             step_carry_s;

  // One bit-step; returns {carry, data}. ASR fills with the sign latched at accept.
  function automatic logic [WIDTH:0] bit_step(input logic [WIDTH-1:0] d,
                                              input logic [2:0]       m,
                                              input logic             sign);
    logic [WIDTH:0] r;
    case (m)
      MODE_LSR: r = {d[0], 1'b0, d[WIDTH-1:1]};
      MODE_LSL: r = {d[WIDTH-1], d[WIDTH-2:0], 1'b0};
      MODE_ASR: r = {d[0], sign, d[WIDTH-1:1]};
      MODE_ROR: r = {d[0], d[0], d[WIDTH-1:1]};
      MODE_ROL: r = {d[WIDTH-1], d[WIDTH-2:0], d[WIDTH-1]};
      default:  r = {1'b0, d};
    endcase
    return r;
  endfunction

  // Decode the request into an effective step count and mode.
  always_comb begin
    n_s    = AMT_ZERO;
    mode_s = MODE_NONE;
    over_s = 1'b0;
    case (in_mode)
      MODE_LSR, MODE_LSL: begin
        n_s    = (in_amount > WIDTH_AMT) ? WIDTH_AMT : in_amount;
        over_s = (in_amount > WIDTH_AMT);
        mode_s = in_mode;
      end
      MODE_ASR: begin
        n_s    = (in_amount > WIDTH_AMT) ? WIDTH_AMT : in_amount;
        mode_s = in_mode;
      end
      MODE_ROR, MODE_ROL: begin
        n_s    = in_amount % WIDTH_AMT;
        mode_s = in_mode;
      end
      default: begin
        n_s    = AMT_ZERO;
        mode_s = MODE_NONE;
      end
    endcase
  end

  // Next data/carry for the current step.
  always_comb begin
    {step_carry_s, step_data_s} = bit_step(data_r, mode_r, sign_r);
  end

  // Control FSM and datapath registers. A zero count still takes one no-op
  // step so the result always appears max(n,1) cycles after acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      data_r  <= {WIDTH{1'b0}};
      cnt_r   <= AMT_ZERO;
      mode_r  <= MODE_NONE;
      carry_r <= 1'b0;
      zero_r  <= 1'b0;
      sign_r  <= 1'b0;
      over_r  <= 1'b0;
      valid_r <= 1'b0;
      ready_r <= 1'b1;
      busy_r  <= 1'b0;
    end else if (flush) begin
      state_r <= IDLE;
      valid_r <= 1'b0;
      ready_r <= 1'b1;
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            data_r  <= in_data;
            sign_r  <= in_data[WIDTH-1];
            carry_r <= 1'b0;
            zero_r  <= 1'b0;
            over_r  <= over_s;
            cnt_r   <= (n_s == AMT_ZERO) ? AMT_ONE : n_s;
            mode_r  <= (n_s == AMT_ZERO) ? MODE_NONE : mode_s;
            state_r <= SHIFT;
            ready_r <= 1'b0;
            busy_r  <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        SHIFT: begin
          data_r  <= step_data_s;
          zero_r  <= ~|step_data_s;
          cnt_r   <= cnt_r - AMT_ONE;
          // Over-range logical shifts report no carry.
          carry_r <= (cnt_r == AMT_ONE && over_r) ? 1'b0 : step_carry_s;
          if (cnt_r == AMT_ONE) begin
            state_r <= DONE;
            valid_r <= 1'b1;
          end else begin
            state_r <= SHIFT;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_r <= IDLE;
            valid_r <= 1'b0;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r <= IDLE;
          valid_r <= 1'b0;
          ready_r <= 1'b1;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = ready_r;
  assign out_valid = valid_r;
  assign out_data  = data_r;
  assign out_carry = carry_r;
  assign out_zero  = zero_r;
  assign busy      = busy_r;

endmodule
